// File: rtl/mgc_inout_arb_wait.sv
// Two-requester arbiter for a shared bidirectional resource port.
// Grants are registered, round-robin on contention, with a one-cycle bus turnaround on direction change.
module mgc_inout_arb_wait #(
    parameter int rscid = 0,
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic             r0_ldin,
    input  logic             r0_ldout,
    input  logic [width-1:0] r0_dout,
    output logic             r0_vdin,
    output logic             r0_vdout,
    output logic [width-1:0] r0_din,
    input  logic             r1_ldin,
    input  logic             r1_ldout,
    input  logic [width-1:0] r1_dout,
    output logic             r1_vdin,
    output logic             r1_vdout,
    output logic [width-1:0] r1_din,
    output logic             lzin,
    output logic             lzout,
    input  logic             vzin,
    input  logic             vzout,
    input  logic [width-1:0] zin,
    output logic [width-1:0] zout,
    output logic             zoe,
    output logic             busy
);

    localparam int rscid_unused = rscid;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t state_r, state_s;
    logic   lo_r, lo_s;
    logic   ld_dir_r, ld_dir_s;
    logic   turn_own_r, turn_own_s;
    logic   req0_s, req1_s;
    logic   win_s, win_wr_s;

    // State, last owner, last direction and pending turnaround owner; all hold while en is low.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_r    <= IDLE;
            lo_r       <= 1'b1;
            ld_dir_r   <= 1'b0;
            turn_own_r <= 1'b0;
        end else if (en) begin
            state_r    <= state_s;
            lo_r       <= lo_s;
            ld_dir_r   <= ld_dir_s;
            turn_own_r <= turn_own_s;
        end else begin
            state_r    <= state_r;
            lo_r       <= lo_r;
            ld_dir_r   <= ld_dir_r;
            turn_own_r <= turn_own_r;
        end
    end

    // Next-state: arbitration in IDLE, one-shot turnaround, release on completion or abandonment.
    always_comb begin
        state_s    = state_r;
        lo_s       = lo_r;
        ld_dir_s   = ld_dir_r;
        turn_own_s = turn_own_r;
        req0_s     = r0_ldin | r0_ldout;
        req1_s     = r1_ldin | r1_ldout;
        // Contention goes to whoever did not own last; a lone requester simply wins.
        win_s      = (req0_s & req1_s) ? ~lo_r : req1_s;
        // Read wins over write whenever ldin is up.
        win_wr_s   = win_s ? ~r1_ldin : ~r0_ldin;
        case (state_r)
            IDLE: begin
                if (req0_s | req1_s) begin
                    if (win_wr_s != ld_dir_r) begin
                        state_s    = TURN;
                        turn_own_s = win_s;
                    end else begin
                        state_s = win_s ? G1 : G0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            TURN: begin
                state_s = turn_own_r ? G1 : G0;
            end
            G0: begin
                if (r0_vdin | r0_vdout) begin
                    state_s  = IDLE;
                    lo_s     = 1'b0;
                    ld_dir_s = r0_vdout;
                end else if (!req0_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = G0;
                end
            end
            G1: begin
                if (r1_vdin | r1_vdout) begin
                    state_s  = IDLE;
                    lo_s     = 1'b1;
                    ld_dir_s = r1_vdout;
                end else if (!req1_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = G1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Outputs: the owner's requests pass straight through to the resource port.
    always_comb begin
        lzin     = 1'b0;
        lzout    = 1'b0;
        zout     = {width{1'b0}};
        zoe      = 1'b0;
        busy     = 1'b0;
        r0_vdin  = 1'b0;
        r0_vdout = 1'b0;
        r0_din   = {width{1'b0}};
        r1_vdin  = 1'b0;
        r1_vdout = 1'b0;
        r1_din   = {width{1'b0}};
        case (state_r)
            G0: begin
                busy     = 1'b1;
                lzin     = r0_ldin;
                lzout    = r0_ldout & ~r0_ldin;
                zout     = r0_dout;
                zoe      = lzout & vzout;
                r0_vdin  = lzin & vzin;
                r0_vdout = lzout & vzout;
                r0_din   = r0_vdin ? zin : {width{1'b0}};
            end
            G1: begin
                busy     = 1'b1;
                lzin     = r1_ldin;
                lzout    = r1_ldout & ~r1_ldin;
                zout     = r1_dout;
                zoe      = lzout & vzout;
                r1_vdin  = lzin & vzin;
                r1_vdout = lzout & vzout;
                r1_din   = r1_vdin ? zin : {width{1'b0}};
            end
            TURN: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mgc_inout_arb_wait.sv
// Randomised and directed bench for mgc_inout_arb_wait against a transaction-level owner model.
module tb_mgc_inout_arb_wait;
    localparam int W = 8;

    logic clk = 1'b0;
    logic arst, en;
    logic r0_ldin, r0_ldout, r1_ldin, r1_ldout, vzin, vzout;
    logic [W-1:0] r0_dout, r1_dout, zin;
    logic r0_vdin, r0_vdout, r1_vdin, r1_vdout, lzin, lzout, zoe, busy;
    logic [W-1:0] r0_din, r1_din, zout;

    int total = 0;
    int bad   = 0;

    // Model: owner (-1 none), pending turnaround owner, last owner, last direction (1 = write).
    int m_own, m_pend;
    bit m_turn, m_lo, m_ld;

    always #5 clk = ~clk;

    mgc_inout_arb_wait #(.rscid(0), .width(W)) dut (
        .clk(clk), .arst(arst), .en(en),
        .r0_ldin(r0_ldin), .r0_ldout(r0_ldout), .r0_dout(r0_dout),
        .r0_vdin(r0_vdin), .r0_vdout(r0_vdout), .r0_din(r0_din),
        .r1_ldin(r1_ldin), .r1_ldout(r1_ldout), .r1_dout(r1_dout),
        .r1_vdin(r1_vdin), .r1_vdout(r1_vdout), .r1_din(r1_din),
        .lzin(lzin), .lzout(lzout), .vzin(vzin), .vzout(vzout),
        .zin(zin), .zout(zout), .zoe(zoe), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ldin_of(input int n);
        return (n == 1) ? r1_ldin : r0_ldin;
    endfunction

    function automatic logic ldout_of(input int n);
        return (n == 1) ? r1_ldout : r0_ldout;
    endfunction

    function automatic logic [W-1:0] dout_of(input int n);
        return (n == 1) ? r1_dout : r0_dout;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_pend = 0;
        m_turn = 1'b0;
        m_lo   = 1'b1;
        m_ld   = 1'b0;
    endtask

    task automatic check_outputs();
        logic e_rd, e_wr;
        logic [W-1:0] e_zout;
        logic [1:0] e_vdin, e_vdout;
        logic [W-1:0] e_din [2];
        e_rd = 1'b0; e_wr = 1'b0; e_zout = '0;
        e_vdin = 2'b00; e_vdout = 2'b00;
        e_din[0] = '0; e_din[1] = '0;
        if (m_own >= 0) begin
            e_rd   = ldin_of(m_own);
            e_wr   = ldout_of(m_own) && !e_rd;
            e_zout = dout_of(m_own);
            e_vdin[m_own]  = e_rd && vzin;
            e_vdout[m_own] = e_wr && vzout;
            if (e_vdin[m_own]) e_din[m_own] = zin;
        end
        check_val("lzin",     {31'b0, lzin},     {31'b0, e_rd});
        check_val("lzout",    {31'b0, lzout},    {31'b0, e_wr});
        check_val("zoe",      {31'b0, zoe},      {31'b0, e_wr && vzout});
        check_val("zout",     {24'b0, zout},     {24'b0, e_zout});
        check_val("busy",     {31'b0, busy},     {31'b0, (m_own >= 0) || m_turn});
        check_val("r0_vdin",  {31'b0, r0_vdin},  {31'b0, e_vdin[0]});
        check_val("r0_vdout", {31'b0, r0_vdout}, {31'b0, e_vdout[0]});
        check_val("r0_din",   {24'b0, r0_din},   {24'b0, e_din[0]});
        check_val("r1_vdin",  {31'b0, r1_vdin},  {31'b0, e_vdin[1]});
        check_val("r1_vdout", {31'b0, r1_vdout}, {31'b0, e_vdout[1]});
        check_val("r1_din",   {24'b0, r1_din},   {24'b0, e_din[1]});
    endtask

    // One clock of the transaction model, using the inputs the DUT just sampled.
    task automatic model_advance();
        logic li, lw, q0, q1;
        int w;
        if (!en) return;
        if (m_turn) begin
            m_own  = m_pend;
            m_turn = 1'b0;
        end else if (m_own >= 0) begin
            li = ldin_of(m_own);
            lw = ldout_of(m_own);
            if ((li && vzin) || (lw && !li && vzout)) begin
                m_lo  = (m_own == 1);
                m_ld  = !li;
                m_own = -1;
            end else if (!li && !lw) begin
                m_own = -1;
            end
        end else begin
            q0 = r0_ldin || r0_ldout;
            q1 = r1_ldin || r1_ldout;
            if (q0 || q1) begin
                if (q0 && q1) w = m_lo ? 0 : 1;
                else          w = q1 ? 1 : 0;
                if ((!ldin_of(w)) != m_ld) begin
                    m_turn = 1'b1;
                    m_pend = w;
                end else begin
                    m_own = w;
                end
            end
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        r0_ldin = 1'b0; r0_ldout = 1'b0; r1_ldin = 1'b0; r1_ldout = 1'b0;
        vzin = 1'b0; vzout = 1'b0;
        r0_dout = '0; r1_dout = '0; zin = '0;
    endtask

    initial begin
        arst = 1'b0;
        en   = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check_val("reset_busy", {31'b0, busy}, 32'd0);
        arst = 1'b1;
        step();

        // Single read by r0, served straight away.
        r0_ldin = 1'b1; vzin = 1'b1; zin = 8'hA5;
        step();
        check_val("req027_lzin", {31'b0, lzin}, 32'd1);
        check_val("req027_vdin", {31'b0, r0_vdin}, 32'd1);
        check_val("req027_din",  {24'b0, r0_din}, 32'h0000_00A5);
        step();
        check_val("req027_idle", {31'b0, busy}, 32'd0);
        clear_inputs();
        step();

        // Both read continuously: round-robin alternation.
        r0_ldin = 1'b1; r1_ldin = 1'b1; vzin = 1'b1;
        for (int i = 0; i < 12; i++) begin
            zin = W'($urandom);
            step();
        end
        clear_inputs();
        step(); step();

        // r1 write after reads: turnaround first.
        r1_ldout = 1'b1; r1_dout = 8'h3C; vzout = 1'b1;
        step();
        check_val("req029_turn_busy", {31'b0, busy}, 32'd1);
        check_val("req029_turn_lzout", {31'b0, lzout}, 32'd0);
        step();
        check_val("req029_lzout", {31'b0, lzout}, 32'd1);
        check_val("req029_zoe", {31'b0, zoe}, 32'd1);
        check_val("req029_zout", {24'b0, zout}, 32'h0000_003C);
        check_val("req029_vdout", {31'b0, r1_vdout}, 32'd1);
        step();
        clear_inputs();
        step();

        // Read and write together: read takes priority.
        r0_ldin = 1'b1; r0_ldout = 1'b1; vzin = 1'b1; vzout = 1'b1; zin = 8'h77;
        step(); step();
        check_val("req030_lzin", {31'b0, lzin}, 32'd1);
        check_val("req030_lzout", {31'b0, lzout}, 32'd0);
        check_val("req030_zoe", {31'b0, zoe}, 32'd0);
        check_val("req030_vdout", {31'b0, r0_vdout}, 32'd0);
        step();
        clear_inputs();
        step();

        // Held grant without valid, then abandonment leaves lo at 0.
        r0_ldin = 1'b1;
        step();
        repeat (5) step();
        check_val("req031_held", {31'b0, busy}, 32'd1);
        r0_ldin = 1'b0;
        step();
        check_val("req031_idle", {31'b0, busy}, 32'd0);
        r0_ldin = 1'b1; r1_ldin = 1'b1; vzin = 1'b1;
        step();
        check_val("req031_r1_wins", {31'b0, r1_vdin}, 32'd1);
        clear_inputs();
        step(); step();

        // Reset in the middle of a G1 write.
        r1_ldout = 1'b1; r1_dout = 8'h5A; vzout = 1'b1;
        for (int i = 0; i < 8 && m_own != 1; i++) step();
        check_val("req032_grant", {31'b0, zoe}, 32'd1);
        #2;
        arst = 1'b0;
        #1;
        model_reset();
        check_val("req032_zoe", {31'b0, zoe}, 32'd0);
        check_val("req032_lzout", {31'b0, lzout}, 32'd0);
        check_val("req032_busy", {31'b0, busy}, 32'd0);
        check_val("req032_vdout", {31'b0, r1_vdout}, 32'd0);
        @(posedge clk);
        #1;
        check_outputs();
        arst = 1'b1;
        clear_inputs();
        r0_ldin = 1'b1; r1_ldin = 1'b1; vzin = 1'b1; zin = 8'hC3;
        step();
        check_val("req032_r0_first", {31'b0, r0_vdin}, 32'd1);
        clear_inputs();
        step(); step();

        // Random traffic including clock-enable gaps.
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            r0_ldin  = ($urandom_range(0, 3) == 0);
            r0_ldout = ($urandom_range(0, 2) == 0);
            r1_ldin  = ($urandom_range(0, 3) == 0);
            r1_ldout = ($urandom_range(0, 2) == 0);
            vzin     = ($urandom_range(0, 1) == 0);
            vzout    = ($urandom_range(0, 1) == 0);
            r0_dout  = W'($urandom);
            r1_dout  = W'($urandom);
            zin      = W'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mgc_inout_arb_wait.md
MGC_INOUT_ARB_WAIT -- requirements
Module: mgc_inout_arb_wait

Interface
REQ-001 Parameters SHALL be: rscid, default 0, resource ID; width, default 8, data width.
REQ-002 Ports SHALL be:
- clk, input, 1 bit, rising-edge clock.
- arst, input, 1 bit, asynchronous reset, active-low.
- en, input, 1 bit, clock enable, active-high.
- r0_ldin, r0_ldout, input, 1 bit each, requester 0 read and write requests.
- r0_dout, input, width bits, requester 0 write data.
- r0_vdin, r0_vdout, output, 1 bit each, requester 0 read and write completion.
- r0_din, output, width bits, requester 0 read data.
- r1_ldin, r1_ldout, r1_dout, r1_vdin, r1_vdout, r1_din: identical to the r0_ set, for requester 1.
- lzin, lzout, output, 1 bit each, resource read and write strobes.
- vzin, vzout, input, 1 bit each, resource read and write valid.
- zin, input, width bits, resource read data.
- zout, output, width bits, resource write data.
- zoe, output, 1 bit, resource output-enable.
- busy, output, 1 bit, a grant is held.

Function
REQ-003 The state machine SHALL have the states IDLE, G0, G1 and TURN, plus a registered last-owner bit (lo) and a registered last-direction bit (ld_dir, where 1 = write).
REQ-004 Requester n is requesting when rn_ldin or rn_ldout is high; its direction SHALL be read whenever rn_ldin is high, because read has priority over write.
REQ-005 Arbitration in IDLE:
- If both requesters request, grant the one that is not lo (round-robin).
- If only one requests, grant that one.
- If neither requests, stay in IDLE.
REQ-006 The grant SHALL be registered: a request sampled at edge N sets state Gn at edge N, and the strobes appear in cycle N+1.
REQ-007 A turnaround is required when the winner's direction differs from ld_dir. In that case IDLE SHALL go to TURN for exactly one cycle, then to Gn. The winner is latched on entry to TURN and is not re-arbitrated.
REQ-008 In Gn, lzin SHALL equal rn_ldin.
REQ-009 In Gn, lzout SHALL equal rn_ldout & ~rn_ldin.
REQ-010 In Gn, zout SHALL equal rn_dout.
REQ-011 In Gn, zoe SHALL equal lzout & vzout.
REQ-012 In Gn, rn_vdin SHALL equal lzin & vzin, and rn_vdout SHALL equal lzout & vzout.
REQ-013 rn_din SHALL equal zin while rn_vdin is high, and 0 otherwise.
REQ-014 In any state other than Gn, requester n's completion outputs SHALL be 0 and its din SHALL be 0.
REQ-015 In IDLE and TURN, lzin, lzout and zoe SHALL be 0, and zout SHALL be 0.
REQ-016 Exactly one transfer per grant: on a completion (rn_vdin or rn_vdout high), Gn SHALL return to IDLE at the next edge, set lo to n, and set ld_dir to the completed direction.
REQ-017 Back-to-back use SHALL cost one IDLE cycle between grants, plus one TURN cycle on a direction change.
REQ-018 Abandonment: if rn_ldin and rn_ldout are both low in Gn, the state SHALL return to IDLE with no completion, and lo and ld_dir SHALL stay unchanged.
REQ-019 A grant SHALL be held indefinitely while the owner keeps requesting without valid; there is no timeout.
REQ-020 A request from the other requester during Gn or TURN SHALL be ignored until IDLE.
REQ-021 When en = 0, all registers SHALL hold. The combinational outputs SHALL still follow REQ-008 to REQ-013 for the held state.
REQ-022 busy SHALL be 1 in G0, G1 and TURN, and 0 in IDLE.
REQ-023 lzin and lzout SHALL never be high in the same cycle. zoe SHALL never be high while lzin is high.

Reset
REQ-024 When arst is low, the block SHALL reset asynchronously, independent of clk and en, to: state IDLE, lo = 1, ld_dir = 0.
REQ-025 During and immediately after reset, every output (all strobes, completions, data outputs, zoe and busy) SHALL be 0.
REQ-026 Reset asserted mid-grant SHALL drop lzin, lzout and zoe in the same cycle, and the interrupted transfer SHALL not be reported as complete.

Verification
REQ-027 Reset, then r0_ldin = 1 with vzin = 1 and zin = 8'hA5 -> G0 in cycle 1 with lzin = 1, r0_vdin = 1, r0_din = 8'hA5 -> IDLE in cycle 2, lo = 0.
REQ-028 r0 and r1 read continuously with vzin = 1 -> grants alternate G1, IDLE, G0, IDLE, G1, and so on, each requester completing one read every 4 cycles.
REQ-029 r1 writes 8'h3C with vzout = 1 after a read -> TURN for one cycle, then G1 with lzout = 1, zoe = 1, zout = 8'h3C, r1_vdout = 1.
REQ-030 r0 asserts ldin and ldout together -> lzin = 1, lzout = 0, zoe = 0; only the read completes.
REQ-031 G0 with vzin held at 0 for 5 cycles, then r0 drops its request -> state returns to IDLE, no completion is reported, and lo is unchanged.
REQ-032 arst driven low during G1 with zoe = 1 -> zoe, lzout and busy go to 0 immediately; after release, state is IDLE, and simultaneous requests grant r0 first.
